// File: rtl/sd_cmd_pkg.sv
// Shared constants for the card-side SD CMD line responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sd_cmd_pkg;

    // Frame geometry
    localparam int FRAME_W   = 48;
    localparam int CRC_MSG_W = 40;
    localparam int CRC_W     = 7;

    // Bit positions inside a 48-bit CMD frame, MSB is sent first
    localparam int BIT_START = 47;
    localparam int BIT_DIR   = 46;
    localparam int IDX_HI    = 45;
    localparam int IDX_LO    = 40;
    localparam int ARG_HI    = 39;
    localparam int ARG_LO    = 8;
    localparam int CRC_HI    = 7;
    localparam int CRC_LO    = 1;
    localparam int BIT_END   = 0;

    // x^7 + x^3 + 1 with the implicit x^7 term dropped
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // Controller states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RECEIVE   = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;
    localparam logic [2:0] ST_SEND      = 3'd5;

    // One serial CRC7 step: shift in one message bit
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one message bit per enabled cycle.
// Latency: oCrc reflects a bit the cycle after it is enabled.
// Backpressure: none; iClear restarts from zero and may coincide with iEnable.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iClear,
    input  logic             iEnable,
    input  logic             iBit,
    output logic [CRC_W-1:0] oCrc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic [CRC_W-1:0] crc_base;

    // Clear and step in the same cycle means "first bit of a new message"
    always_comb begin
        crc_base = iClear ? '0 : crc_q;
        crc_d    = iEnable ? crc7_step(crc_base, iBit) : crc_base;
    end

    // CRC register
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign oCrc = crc_q;

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side CMD line: deserialize/check host commands, serialize R1-style responses.
// Latency: command pulse 48 edges after the start-bit edge; response starts NCR cycles after accept.
// Backpressure: oResp_ready/iResp_valid handshake, abandoned after RESP_TIMEOUT cycles.
module sd_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic        iCmd_in,
    output logic        oCmd_out,
    output logic        oCmd_oe,
    output logic        oCommand_valid,
    output logic [5:0]  oCmd_index,
    output logic [31:0] oCmd_argument,
    output logic        oCrc_error,
    output logic        oFrame_error,
    output logic        oResp_ready,
    input  logic        iResp_valid,
    input  logic        iResp_none,
    input  logic [31:0] iResp_data,
    output logic        oResp_timeout,
    output logic        oBusy
);

    // One counter serves bit position, timeout and gap; wide enough for all
    localparam int CNT_W = 16;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [5:0]         idx_q, idx_d;
    logic [31:0]        arg_q, arg_d;
    logic               valid_q, valid_d;
    logic               crc_err_q, crc_err_d;
    logic               frame_err_q, frame_err_d;
    logic               timeout_q, timeout_d;

    logic               crc_clr;
    logic               crc_en;
    logic               crc_bit;
    logic [CRC_W-1:0]   crc;
    logic               cmd_out;

    sd_crc7 u_crc7 (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .iClear   (crc_clr),
        .iEnable  (crc_en),
        .iBit     (crc_bit),
        .oCrc     (crc)
    );

    // Next-state logic for receive, check, response handshake and transmit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = iCmd_in;

        case (state_q)
            ST_IDLE: begin
                // Start bit doubles as the first CRC message bit
                if (!iCmd_in) begin
                    state_d = ST_RECEIVE;
                    cnt_d   = CNT_W'(BIT_DIR);
                    shreg_d = '0;
                    crc_clr = 1'b1;
                    crc_en  = 1'b1;
                end
            end

            ST_RECEIVE: begin
                shreg_d = {shreg_q[FRAME_W-2:0], iCmd_in};
                crc_en  = (cnt_q >= CNT_W'(ARG_LO));
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!shreg_q[BIT_DIR] || !shreg_q[BIT_END]) begin
                    frame_err_d = 1'b1;
                end else if (shreg_q[CRC_HI:CRC_LO] != crc) begin
                    crc_err_d = 1'b1;
                end else begin
                    idx_d   = shreg_q[IDX_HI:IDX_LO];
                    arg_d   = shreg_q[ARG_HI:ARG_LO];
                    valid_d = 1'b1;
                    state_d = ST_WAIT_RESP;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_RESP: begin
                // A handshake on the expiry cycle wins over the timeout
                if (iResp_valid) begin
                    if (iResp_none) begin
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = {2'b00, idx_q, iResp_data, 8'hFF};
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(NCR - 1)) begin
                    state_d = ST_SEND;
                    cnt_d   = CNT_W'(BIT_START);
                    crc_clr = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SEND: begin
                crc_bit = shreg_q[FRAME_W-1];
                crc_en  = (cnt_q >= CNT_W'(ARG_LO));
                shreg_d = {shreg_q[FRAME_W-2:0], 1'b1};
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            idx_q       <= '0;
            arg_q       <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Transmit mux: payload from the shifter, then CRC7 MSB first, then end bit
    always_comb begin
        cmd_out = 1'b1;
        if (state_q == ST_SEND) begin
            if (cnt_q >= CNT_W'(ARG_LO)) begin
                cmd_out = shreg_q[FRAME_W-1];
            end else if (cnt_q != '0) begin
                cmd_out = crc[3'(cnt_q[2:0] - 3'd1)];
            end
        end
    end

    // Line enable follows state directly so reset releases the line at once
    assign oCmd_out       = cmd_out;
    assign oCmd_oe        = (state_q == ST_SEND);
    assign oCommand_valid = valid_q;
    assign oCmd_index     = idx_q;
    assign oCmd_argument  = arg_q;
    assign oCrc_error     = crc_err_q;
    assign oFrame_error   = frame_err_q;
    assign oResp_ready    = (state_q == ST_WAIT_RESP);
    assign oResp_timeout  = timeout_q;
    assign oBusy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: directed frames plus random commands.
// Latency: n/a.
// Backpressure: bench drives the response handshake with random delays.
module tb_sd_cmd_responder;

    localparam int NCR          = 2;
    localparam int RESP_TIMEOUT = 64;

    logic        iClock;
    logic        iReset_n;
    logic        iCmd_in;
    logic        oCmd_out;
    logic        oCmd_oe;
    logic        oCommand_valid;
    logic [5:0]  oCmd_index;
    logic [31:0] oCmd_argument;
    logic        oCrc_error;
    logic        oFrame_error;
    logic        oResp_ready;
    logic        iResp_valid;
    logic        iResp_none;
    logic [31:0] iResp_data;
    logic        oResp_timeout;
    logic        oBusy;

    sd_cmd_responder #(
        .NCR          (NCR),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .iClock         (iClock),
        .iReset_n       (iReset_n),
        .iCmd_in        (iCmd_in),
        .oCmd_out       (oCmd_out),
        .oCmd_oe        (oCmd_oe),
        .oCommand_valid (oCommand_valid),
        .oCmd_index     (oCmd_index),
        .oCmd_argument  (oCmd_argument),
        .oCrc_error     (oCrc_error),
        .oFrame_error   (oFrame_error),
        .oResp_ready    (oResp_ready),
        .iResp_valid    (iResp_valid),
        .iResp_none     (iResp_none),
        .iResp_data     (iResp_data),
        .oResp_timeout  (oResp_timeout),
        .oBusy          (oBusy)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_valid, n_crc, n_frame, n_to, n_oe, n_ready, out_bad;
    int          first_oe, to_cyc;
    logic [47:0] resp_bits;
    logic [5:0]  mdl_idx = '0;
    logic [31:0] mdl_arg = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        logic [46:0] poly;
        r    = {msg, 7'b0};
        poly = 47'h89;
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (poly << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_ref(m), 1'b1};
    endfunction

    function automatic logic [47:0] card_frame(input logic [5:0] idx, input logic [31:0] data);
        logic [39:0] m;
        m = {2'b00, idx, data};
        return {m, crc7_ref(m), 1'b1};
    endfunction

    task automatic clear_stats();
        n_valid = 0; n_crc = 0; n_frame = 0; n_to = 0; n_oe = 0; n_ready = 0;
        out_bad = 0; first_oe = -1; to_cyc = -1; resp_bits = '0;
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge
    task automatic tick();
        @(posedge iClock);
        #1;
        cyc++;
        if (oCommand_valid) n_valid++;
        if (oCrc_error)     n_crc++;
        if (oFrame_error)   n_frame++;
        if (oResp_ready)    n_ready++;
        if (oResp_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (oCmd_oe) begin
            if (n_oe == 0) first_oe = cyc;
            n_oe++;
            resp_bits = {resp_bits[46:0], oCmd_out};
        end else if (oCmd_out !== 1'b1) begin
            out_bad++;
        end
    endtask

    // mode 0: answer "no response"; 1: answer with rdata; 2: never answer
    task automatic run_cmd(input logic [47:0] f, input int mode, input int d,
                           input logic [31:0] rdata, input bit noise, input int abort_at);
        int kind, tv, th;
        kind = (!f[46] || !f[0]) ? 2 : ((f[7:1] != crc7_ref(f[47:8])) ? 1 : 0);
        clear_stats();
        for (int i = 47; i >= 0; i--) begin
            iCmd_in = f[i];
            tick();
        end
        check_eq("early_pulse", 64'(n_valid + n_crc + n_frame), 64'(0));
        iCmd_in = 1'b1;
        tick();
        tv = cyc;
        check_eq("cmd_valid", 64'(oCommand_valid), 64'(kind == 0));
        check_eq("crc_error", 64'(oCrc_error), 64'(kind == 1));
        check_eq("frame_error", 64'(oFrame_error), 64'(kind == 2));
        if (kind != 0) begin
            check_eq("idx_hold", 64'(oCmd_index), 64'(mdl_idx));
            check_eq("arg_hold", 64'(oCmd_argument), 64'(mdl_arg));
            check_eq("busy_after_err", 64'(oBusy), 64'(0));
            return;
        end
        mdl_idx = f[45:40];
        mdl_arg = f[39:8];
        check_eq("cmd_index", 64'(oCmd_index), 64'(mdl_idx));
        check_eq("cmd_arg", 64'(oCmd_argument), 64'(mdl_arg));
        check_eq("resp_ready", 64'(oResp_ready), 64'(1));

        if (mode == 2) begin
            for (int k = 0; k < 200 && n_to == 0; k++) begin
                if (noise) iCmd_in = 1'($urandom % 2);
                tick();
            end
            iCmd_in = 1'b1;
            check_eq("timeout_seen", 64'(n_to), 64'(1));
            check_eq("timeout_cycle", 64'(to_cyc - tv), 64'(RESP_TIMEOUT));
            check_eq("ready_cycles", 64'(n_ready), 64'(RESP_TIMEOUT));
            tick();
            check_eq("busy_after_to", 64'(oBusy), 64'(0));
            check_eq("oe_after_to", 64'(n_oe), 64'(0));
            return;
        end

        for (int k = 0; k < d; k++) begin
            if (noise) iCmd_in = 1'($urandom % 2);
            tick();
        end
        iResp_valid = 1'b1;
        iResp_none  = (mode == 0);
        iResp_data  = rdata;
        tick();
        th = cyc;
        iResp_valid = 1'b0;
        iResp_none  = 1'b0;
        check_eq("ready_cycles", 64'(n_ready), 64'(d + 1));

        if (mode == 0) begin
            iCmd_in = 1'b1;
            check_eq("busy_after_none", 64'(oBusy), 64'(0));
            check_eq("oe_none", 64'(n_oe), 64'(0));
            check_eq("no_timeout", 64'(n_to), 64'(0));
            return;
        end

        for (int k = 0; k < 200 && n_oe < 48; k++) begin
            if (noise) iCmd_in = 1'($urandom % 2);
            tick();
            if (abort_at >= 0 && n_oe == abort_at) break;
        end
        iCmd_in = 1'b1;
        check_eq("gap_len", 64'(first_oe - th), 64'(NCR));
        if (abort_at >= 0) begin
            #2 iReset_n = 1'b0;
            #1;
            check_eq("rst_oe", 64'(oCmd_oe), 64'(0));
            check_eq("rst_out", 64'(oCmd_out), 64'(1));
            check_eq("rst_busy", 64'(oBusy), 64'(0));
            check_eq("rst_idx", 64'(oCmd_index), 64'(0));
            check_eq("rst_arg", 64'(oCmd_argument), 64'(0));
            mdl_idx = '0;
            mdl_arg = '0;
            repeat (2) @(posedge iClock);
            @(negedge iClock);
            iReset_n = 1'b1;
            return;
        end
        check_eq("oe_cycles", 64'(n_oe), 64'(48));
        check_eq("resp_frame", 64'(resp_bits), 64'(card_frame(mdl_idx, rdata)));
        tick();
        check_eq("oe_release", 64'(oCmd_oe), 64'(0));
        check_eq("busy_after_send", 64'(oBusy), 64'(0));
        check_eq("no_timeout", 64'(n_to), 64'(0));
        check_eq("idle_line", 64'(out_bad), 64'(0));
    endtask

    initial begin
        logic [47:0] f;
        int          corrupt;
        iReset_n    = 1'b0;
        iCmd_in     = 1'b1;
        iResp_valid = 1'b0;
        iResp_none  = 1'b0;
        iResp_data  = '0;
        #12;
        check_eq("reset_oe", 64'(oCmd_oe), 64'(0));
        check_eq("reset_out", 64'(oCmd_out), 64'(1));
        check_eq("reset_busy", 64'(oBusy), 64'(0));
        check_eq("reset_ready", 64'(oResp_ready), 64'(0));
        check_eq("reset_pulses", 64'({oCommand_valid, oCrc_error, oFrame_error, oResp_timeout}), 64'(0));
        check_eq("reset_idx", 64'(oCmd_index), 64'(0));
        check_eq("reset_arg", 64'(oCmd_argument), 64'(0));
        @(negedge iClock);
        iReset_n = 1'b1;
        tick();
        tick();

        // CMD0, no response
        run_cmd(48'h40_0000_0000_95, 0, 3, 32'h0, 1'b0, -1);
        // CMD8, R1 response with 0x120
        run_cmd(48'h48_0000_01AA_87, 1, 5, 32'h0000_0120, 1'b0, -1);
        // CMD17 with corrupted CRC byte
        run_cmd(48'h51_0000_0000_57, 0, 0, 32'h0, 1'b0, -1);
        // All-ones after start: bad CRC; then end bit 0 too: frame error wins
        run_cmd(48'h7FFF_FFFF_FFFF, 0, 0, 32'h0, 1'b0, -1);
        run_cmd(48'h7FFF_FFFF_FFFE, 0, 0, 32'h0, 1'b0, -1);
        // Timeout, then handshake on the expiry cycle
        run_cmd(48'h40_0000_0000_95, 2, 0, 32'h0, 1'b0, -1);
        run_cmd(48'h40_0000_0000_95, 1, RESP_TIMEOUT - 1, 32'hDEAD_BEEF, 1'b0, -1);
        // Reset in the middle of a response, then a fresh CMD0
        run_cmd(48'h48_0000_01AA_87, 1, 2, 32'h0000_0900, 1'b0, 20);
        run_cmd(48'h40_0000_0000_95, 0, 1, 32'h0, 1'b0, -1);

        // Random commands with noise on the line while it is ignored
        for (int n = 0; n < 30; n++) begin
            f = host_frame(6'($urandom % 64), $urandom);
            corrupt = int'($urandom % 8);
            if (corrupt == 0) f[1 + ($urandom % 7)] = ~f[1 + ($urandom % 7)];
            else if (corrupt == 1) f[0] = 1'b0;
            else if (corrupt == 2) f[46] = 1'b0;
            run_cmd(f, int'($urandom % 3), int'($urandom % RESP_TIMEOUT), $urandom, 1'b1, -1);
            for (int g = 0; g < int'($urandom % 3); g++) begin
                iCmd_in = 1'b1;
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
Card-side end of the SD CMD line. It deserializes the 48-bit command frames sent by the host command controller and checks their framing and CRC7. Valid commands are presented to card logic, which answers with a response payload. The block then serializes a 48-bit R1-style response back onto the CMD line after an NCR gap. It sits opposite the host CMD control block and serves as its bench/behavioural counterpart.

Parameters:
NCR, 2, idle cycles (line released) between response accept and response start bit; legal range 2..64
RESP_TIMEOUT, 64, cycles to wait in WAIT_RESP for iResp_valid before abandoning the command

Ports:
iClock  in  1  CMD line clock; all logic on rising edge
iReset_n  in  1  asynchronous, active-low reset
iCmd_in  in  1  serial CMD line from host, MSB first; idles at 1
oCmd_out  out  1  serial response bit; 1 when not driving
oCmd_oe  out  1  card drives CMD line when 1
oCommand_valid  out  1  one-cycle pulse: good command latched
oCmd_index  out  6  latched command index
oCmd_argument  out  32  latched command argument
oCrc_error  out  1  one-cycle pulse: CRC7 mismatch
oFrame_error  out  1  one-cycle pulse: transmission bit != 1 or end bit != 1
oResp_ready  out  1  high in WAIT_RESP
iResp_valid  in  1  response handshake; accepted when iResp_valid && oResp_ready
iResp_none  in  1  sampled with iResp_valid; 1 = no response for this command
iResp_data  in  32  response payload (card status)
oResp_timeout  out  1  one-cycle pulse: RESP_TIMEOUT expired
oBusy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; oCmd_out=1; oCmd_oe=0; all pulses, oResp_ready and oBusy 0; oCmd_index=0; oCmd_argument=0. Reset during SEND drops oCmd_oe immediately.
- States: IDLE, RECEIVE, CHECK, WAIT_RESP, GAP, SEND.
- IDLE: when iCmd_in==0 is sampled, capture it as bit 47 and go to RECEIVE with bit counter 46.
- RECEIVE: shift in one bit per cycle, MSB first, until bit 0. CRC7 (poly x^7+x^3+1, init 0) runs serially over bits 47..8. Then go to CHECK.
- CHECK (1 cycle):
  - If bit46!=1 or bit0!=1: pulse oFrame_error, go to IDLE.
  - Else if bits[7:1] != computed CRC: pulse oCrc_error, go to IDLE.
  - Else: latch index=bits[45:40] and argument=bits[39:8], pulse oCommand_valid, go to WAIT_RESP.
  - oFrame_error takes priority over oCrc_error. The outputs hold their previous values on error.
- WAIT_RESP: oResp_ready=1 and the timeout counter runs.
  - Handshake with iResp_none=1: go to IDLE.
  - Handshake with iResp_none=0: latch iResp_data and go to GAP.
  - RESP_TIMEOUT cycles without a handshake: pulse oResp_timeout, go to IDLE.
  - A handshake in the same cycle the counter expires wins over the timeout.
- GAP: NCR cycles with oCmd_oe=0, then go to SEND.
- SEND: 48 cycles with oCmd_oe=1, driving bits MSB first:
  - 0, 0 (transmission bit = card)
  - latched index[5:0], then resp_data[31:0]
  - CRC7 over the preceding 40 bits, then end bit 1
  - The cycle after the end bit: oCmd_oe=0, state IDLE.
- iCmd_in is ignored in every state except IDLE/RECEIVE; the line is half-duplex.
- First bit of RECEIVE is the cycle after start detect. Latency from start bit to oCommand_valid is 49 cycles.
- Back-to-back commands: a start bit in the first IDLE cycle after SEND/CHECK is detected.

Decomposition:
- Shared package sd_cmd_pkg:
  - state encoding
  - frame widths (48, 40, 7)
  - bit positions: START=47, DIR=46, IDX 45:40, ARG 39:8, CRC 7:1, END=0
  - CRC7 polynomial constant 7'h09
- Sub-module sd_crc7: serial CRC7.
  - Ports: iClock, iReset_n, iClear, iEnable, iBit, oCrc[6:0].
  - One instance is shared by receive and send; it is cleared on entering RECEIVE/SEND.

Test Plan:
- CMD0 frame 48'h40_0000_0000_95 -> oCommand_valid at cycle 49, index 0, argument 0. Then iResp_none=1 -> IDLE, oCmd_oe never asserted.
- CMD8 frame 48'h48_0000_01AA_87 -> index 8, argument 32'h1AA. Then iResp_data=32'h0000_0120 -> after NCR=2 gap, line carries 48'h08_0000_0120 plus CRC7 and end bit; oCmd_oe high exactly 48 cycles.
- CMD17 arg 0 with CRC byte corrupted to 8'h57 (correct is 8'h55) -> oCrc_error pulse, no oCommand_valid, back in IDLE.
- Frame 48'hFFFF_FFFF_FFFF preceded by forced start 0 (transmission bit ok, bad CRC, end 1) vs. frame with end bit 0 -> oCrc_error vs. oFrame_error respectively. Frame error wins when both apply.
- Valid command with no iResp_valid -> oResp_timeout pulse after 64 cycles, oBusy low next cycle. Handshake on the expiry cycle -> response sent, no timeout pulse.
- iReset_n low at SEND bit 20 -> oCmd_oe=0 and oCmd_out=1 immediately. After release, a new CMD0 is received correctly.
